// File: rtl/k_counter.sv
// Random-walk K-counter loop filter: two modulo-K counters integrate dn_up into carry/borrow pulses.
// Latency: carry/borrow are registered and high for the one cycle after the wrapping edge; net follows one edge later.
// Backpressure: none; en=0 freezes both counters, a modulus change clears them and costs one counting edge.
module k_counter #(
    parameter int KW = 17,
    parameter int NW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 dn_up,
    input  logic [3:0]           k_sel,
    output logic                 carry,
    output logic                 borrow,
    output logic signed [NW-1:0] net
);

    // Largest legal exponent offset: K = 2^(k_reg+3) must fit in KW bits.
    localparam logic [3:0] K_MAX = 4'(KW - 3);

    localparam logic signed [NW-1:0] NET_MAX = {1'b0, {(NW-1){1'b1}}};
    localparam logic signed [NW-1:0] NET_MIN = {1'b1, {(NW-1){1'b0}}};

    logic [KW-1:0] up_cnt;
    logic [KW-1:0] dn_cnt;
    logic [3:0]    k_reg;
    logic [3:0]    k_clamp;
    logic [KW-1:0] wrap_val;
    logic          up_wrap;
    logic          dn_wrap;

    // Clamp the requested modulus so K never exceeds the counter width.
    always_comb begin
        k_clamp = (k_sel > K_MAX) ? K_MAX : k_sel;
    end

    // K-1 is all-ones in the low k_reg+3 bits; upper counter bits are always
    // zero, so a full-width equality compare is exact.
    always_comb begin
        wrap_val = '0;
        for (int i = 0; i < KW; i++) begin
            wrap_val[i] = (i < (int'(k_reg) + 3));
        end
    end

    assign up_wrap = (up_cnt == wrap_val);
    assign dn_wrap = (dn_cnt == wrap_val);

    // Counter and pulse registers: modulus change > disable > up or down count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_cnt <= '0;
            dn_cnt <= '0;
            k_reg  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else if (k_clamp != k_reg) begin
            // New loop bandwidth: restart both integrators from zero.
            k_reg  <= k_clamp;
            up_cnt <= '0;
            dn_cnt <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else if (!en) begin
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else if (!dn_up) begin
            borrow <= 1'b0;
            if (up_wrap) begin
                up_cnt <= '0;
                carry  <= 1'b1;
            end else begin
                up_cnt <= up_cnt + KW'(1);
                carry  <= 1'b0;
            end
        end else begin
            carry <= 1'b0;
            if (dn_wrap) begin
                dn_cnt <= '0;
                borrow <= 1'b1;
            end else begin
                dn_cnt <= dn_cnt + KW'(1);
                borrow <= 1'b0;
            end
        end
    end

    // Net correction monitor: counts registered pulses, saturating both ways,
    // and survives modulus changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            net <= '0;
        end else if (carry && (net != NET_MAX)) begin
            net <= net + NW'(1);
        end else if (borrow && (net != NET_MIN)) begin
            net <= net - NW'(1);
        end
    end

endmodule

// File: tb/tb_k_counter.sv
// Directed bench for k_counter: table-driven per-edge vectors plus async reset sequences.
// Latency: each vector drives inputs, waits one rising edge, samples 1 time unit later.
// Backpressure: not applicable; a watchdog bounds the run.
module tb_k_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       dn_up = 1'b0;
    logic [3:0] k_sel = 4'd0;

    logic              carry, borrow;
    logic signed [7:0] net;
    logic              carry_s, borrow_s;
    logic signed [7:0] net_s;

    typedef struct {
        logic              en;
        logic              dn_up;
        logic [3:0]        k_sel;
        logic              carry;
        logic              borrow;
        logic signed [7:0] net;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   use_small = 1'b0;

    k_counter #(.KW(17), .NW(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .dn_up(dn_up), .k_sel(k_sel),
        .carry(carry), .borrow(borrow), .net(net)
    );

    // Narrow instance so the clamp to 2^KW can be exercised in few cycles.
    k_counter #(.KW(5), .NW(8)) u_small (
        .clk(clk), .reset(reset), .en(en), .dn_up(dn_up), .k_sel(k_sel),
        .carry(carry_s), .borrow(borrow_s), .net(net_s)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic e, input logic d, input logic [3:0] k,
                                input logic c, input logic b, input int n);
        vec_t v;
        v.en = e; v.dn_up = d; v.k_sel = k;
        v.carry = c; v.borrow = b; v.net = 8'(n);
        return v;
    endfunction

    task automatic check_now(input string name, input logic c, input logic b,
                             input logic signed [7:0] n);
        logic              oc, ob;
        logic signed [7:0] on;
        oc = use_small ? carry_s : carry;
        ob = use_small ? borrow_s : borrow;
        on = use_small ? net_s : net;
        n_vec++;
        if ({oc, ob, on} !== {c, b, n}) begin
            n_bad++;
            $display("FAIL %s #%0d: got carry=%b borrow=%b net=%0d, want carry=%b borrow=%b net=%0d",
                     name, n_vec, oc, ob, on, c, b, n);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        en = v.en; dn_up = v.dn_up; k_sel = v.k_sel;
        @(posedge clk);
        #1;
        check_now(name, v.carry, v.borrow, v.net);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], name);
        tbl.delete();
    endtask

    // Hold reset across two edges, check the cleared state, release 1 unit after an edge.
    task automatic do_reset(input string name);
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_now(name, 1'b0, 1'b0, 8'sd0);
        reset = 1'b1;
    endtask

    initial begin
        // K=8 up counting: carry after the 8th and 16th enabled edges.
        do_reset("reset_state");
        for (int i = 1; i <= 17; i++)
            tbl.push_back(mk(1, 0, 4'd0, (i == 8) || (i == 16), 0, int'(i >= 9) + int'(i >= 17)));
        run_table("up_k8");

        // K=32 down counting: edge 1 loads the modulus, borrow after edges 33 and 65.
        do_reset("reset_b");
        for (int i = 1; i <= 70; i++)
            tbl.push_back(mk(1, 1, 4'd2, 0, (i == 33) || (i == 65), -(int'(i >= 34) + int'(i >= 66))));
        run_table("down_k32");

        // K=8 alternating dn_up: both counters advance independently.
        do_reset("reset_c");
        for (int i = 1; i <= 33; i++)
            tbl.push_back(mk(1, (i % 2) == 0, 4'd0, (i == 15) || (i == 31), (i == 16) || (i == 32),
                             int'(i >= 16) - int'(i >= 17) + int'(i >= 32) - int'(i >= 33)));
        run_table("alternate");

        // Modulus change at up_cnt=6: clearing edge, then K=16 needs 16 edges.
        do_reset("reset_d");
        for (int i = 1; i <= 6; i++) tbl.push_back(mk(1, 0, 4'd0, 0, 0, 0));
        for (int i = 7; i <= 24; i++) tbl.push_back(mk(1, 0, 4'd1, i == 23, 0, int'(i >= 24)));
        run_table("kchange");

        // Freeze at up_cnt=5 for 20 edges, then carry on the 3rd enabled edge;
        // dropping en during the pulse still ends it normally.
        do_reset("reset_e");
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(1, 0, 4'd0, 0, 0, 0));
        for (int i = 6; i <= 25; i++) tbl.push_back(mk(0, 0, 4'd0, 0, 0, 0));
        for (int i = 26; i <= 28; i++) tbl.push_back(mk(1, 0, 4'd0, i == 28, 0, 0));
        tbl.push_back(mk(0, 0, 4'd0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'd0, 0, 0, 1));
        run_table("enable");

        // 130 carries at K=8: net saturates at +127.
        do_reset("reset_f");
        for (int i = 1; i <= 1041; i++) begin
            int n;
            n = (i - 1) / 8;
            if (n > 127) n = 127;
            tbl.push_back(mk(1, 0, 4'd0, (i % 8) == 0, 0, n));
        end
        run_table("sat_pos");

        // 130 borrows at K=8: net saturates at -128.
        do_reset("reset_g");
        for (int i = 1; i <= 1041; i++) begin
            int n;
            n = (i - 1) / 8;
            if (n > 128) n = 128;
            tbl.push_back(mk(1, 1, 4'd0, 0, (i % 8) == 0, -n));
        end
        run_table("sat_neg");

        // Reset asserted while carry is high: carry drops without a clock edge.
        do_reset("reset_h");
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 0, 4'd0, i == 8, 0, 0));
        run_table("pre_pulse");
        #2;
        reset = 1'b0;
        #1;
        check_now("async_drop", 1'b0, 1'b0, 8'sd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(1, 0, 4'd0, 0, 0, 0));
        run_table("after_release");
        // Mid-count reset at up_cnt=5: a fresh 8 edges are needed for the next carry.
        #2;
        reset = 1'b0;
        #1;
        check_now("midcount_reset", 1'b0, 1'b0, 8'sd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 9; i++) tbl.push_back(mk(1, 0, 4'd0, i == 8, 0, int'(i >= 9)));
        run_table("midcount_resume");

        // KW=5: k_sel 15, 2 and 3 all clamp to K=32, so changing between them
        // is not a modulus change. Edge 1 loads the modulus, carry after edge 33.
        use_small = 1'b1;
        do_reset("reset_small");
        for (int i = 1; i <= 34; i++)
            tbl.push_back(mk(1, 0, (i < 10) ? 4'd15 : ((i < 20) ? 4'd2 : 4'd3), i == 33, 0, int'(i >= 34)));
        run_table("clamp");
        use_small = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
